// File: rtl/tinynpu_layer_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tinynpu_layer_sched
//
// Host-side sequencer for the TinyNPU. Accepts one inference command, fetches
// the input vector and each layer's weight rows over a single-outstanding
// memory read port, streams them into the NPU load interface, fires one MAC
// start per layer and waits for the NPU to report the layer finished. After
// layer 0 the NPU feeds its own outputs back as inputs, so only weights are
// fetched for later layers.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_cmd_val / o_cmd_rdy   command handshake (ready only while idle)
//   i_cmd_len               K, elements per row (clamped to DEPTH)
//   i_cmd_layers            number of layers
//   i_cmd_base              base address of x followed by all weights
//   o_mem_req_val/i_mem_req_rdy/o_mem_req_addr   read request
//   i_mem_resp_val/i_mem_resp_data               read response
//   o_npu_x_load_val        1-cycle pulse: load o_npu_load_data into x FIFO
//   o_npu_w_load_val        1-cycle pulse: load o_npu_load_data into w FIFO
//   o_npu_w_load_sel        target weight row for the w load
//   o_npu_load_data         registered load data
//   o_npu_mac_val           1-cycle MAC start pulse
//   i_npu_layer_done        NPU finished the layer and is idle
//   o_busy                  command in progress
//   o_done                  1-cycle pulse when the command completes
// ---------------------------------------------------------------------------
module tinynpu_layer_sched #(
  parameter  int SIZE  = 4,
  parameter  int DEPTH = 8,
  parameter  int AW    = 8,
  parameter  int DW    = 8,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int SW    = $clog2(SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_val,
  output logic          o_cmd_rdy,
  input  logic [LW-1:0] i_cmd_len,
  input  logic [3:0]    i_cmd_layers,
  input  logic [AW-1:0] i_cmd_base,
  output logic          o_mem_req_val,
  input  logic          i_mem_req_rdy,
  output logic [AW-1:0] o_mem_req_addr,
  input  logic          i_mem_resp_val,
  input  logic [DW-1:0] i_mem_resp_data,
  output logic          o_npu_x_load_val,
  output logic          o_npu_w_load_val,
  output logic [SW-1:0] o_npu_w_load_sel,
  output logic [DW-1:0] o_npu_load_data,
  output logic          o_npu_mac_val,
  input  logic          i_npu_layer_done,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDX,
    S_LDW,
    S_MAC,
    S_WAIT,
    S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [LW-1:0] r_len;
  logic [3:0]    r_layers;
  logic [3:0]    r_layer_cnt;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_k;
  logic [SW-1:0] r_row;
  logic          r_pend;
  logic          r_x_load;
  logic          r_w_load;
  logic [SW-1:0] r_sel;
  logic [DW-1:0] r_data;
  logic          r_mac;

  logic [LW-1:0] w_len_clamp;
  logic          w_fetching;
  logic          w_req_val;
  logic          w_req_fire;
  logic          w_resp;
  logic          w_last_k;
  logic          w_last_row;
  logic          w_last_layer;
  logic          w_cmd_fire;
  logic          w_layer_done;

  assign w_len_clamp = (i_cmd_len > LW'(DEPTH)) ? LW'(DEPTH) : i_cmd_len;
  assign w_cmd_fire  = (r_state == S_IDLE) && i_cmd_val;
  assign w_fetching  = (r_state == S_LDX) || (r_state == S_LDW);
  assign w_req_val   = w_fetching && !r_pend;
  assign w_req_fire  = w_req_val && i_mem_req_rdy;
  // A response is only meaningful while one is owed: either the request is
  // already outstanding, or it is being handshaken this very cycle.
  assign w_resp      = w_fetching && i_mem_resp_val && (r_pend || w_req_fire);
  assign w_last_k    = (r_k == (r_len - LW'(1)));
  assign w_last_row  = (r_row == SW'(SIZE - 1));
  assign w_last_layer = ((r_layer_cnt + 4'd1) == r_layers);
  // While the MAC pulse is still on the wire the NPU cannot have finished,
  // so a layer_done seen then is stale and ignored.
  assign w_layer_done = (r_state == S_WAIT) && i_npu_layer_done && !r_mac;

  assign o_mem_req_addr   = r_addr;
  assign o_npu_x_load_val = r_x_load;
  assign o_npu_w_load_val = r_w_load;
  assign o_npu_w_load_sel = r_sel;
  assign o_npu_load_data  = r_data;
  assign o_npu_mac_val    = r_mac;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_cmd_rdy     = 1'b0;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    o_mem_req_val = w_req_val;
    unique case (r_state)
      S_IDLE: begin
        o_cmd_rdy = 1'b1;
        o_busy    = 1'b0;
        if (i_cmd_val) begin
          w_next = ((w_len_clamp == '0) || (i_cmd_layers == '0)) ? S_FIN : S_LDX;
        end
      end
      S_LDX: begin
        if (w_resp && w_last_k) w_next = S_LDW;
      end
      S_LDW: begin
        if (w_resp && w_last_k && w_last_row) w_next = S_MAC;
      end
      S_MAC: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_layer_done) w_next = w_last_layer ? S_FIN : S_LDW;
      end
      S_FIN: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: command latch, fetch bookkeeping and the registered NPU load
  // interface. Addresses for x and every layer's weights are contiguous, so
  // a single running pointer covers the whole command.
  // The MAC pulse is registered out of the MAC state so it always lands one
  // cycle after the final weight load of the layer, never alongside it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len       <= '0;
      r_layers    <= '0;
      r_layer_cnt <= '0;
      r_addr      <= '0;
      r_k         <= '0;
      r_row       <= '0;
      r_pend      <= 1'b0;
      r_x_load    <= 1'b0;
      r_w_load    <= 1'b0;
      r_sel       <= '0;
      r_data      <= '0;
      r_mac       <= 1'b0;
    end else begin
      r_x_load <= 1'b0;
      r_w_load <= 1'b0;
      r_mac    <= (r_state == S_MAC);

      if (w_cmd_fire) begin
        r_len       <= w_len_clamp;
        r_layers    <= i_cmd_layers;
        r_addr      <= i_cmd_base;
        r_k         <= '0;
        r_row       <= '0;
        r_layer_cnt <= '0;
        r_pend      <= 1'b0;
      end

      if (w_resp) begin
        r_pend <= 1'b0;
      end else if (w_req_fire) begin
        r_pend <= 1'b1;
      end

      if (w_resp) begin
        r_data <= i_mem_resp_data;
        r_addr <= r_addr + AW'(1);
        if (r_state == S_LDX) begin
          r_x_load <= 1'b1;
        end else begin
          r_w_load <= 1'b1;
          r_sel    <= r_row;
        end
        if (w_last_k) begin
          r_k <= '0;
          if (r_state == S_LDW) begin
            r_row <= w_last_row ? '0 : r_row + SW'(1);
          end
        end else begin
          r_k <= r_k + LW'(1);
        end
      end

      if (w_layer_done) begin
        r_layer_cnt <= r_layer_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tinynpu_layer_sched.sv
`timescale 1ns/1ps
// Testbench for tinynpu_layer_sched. A reference model expands each command
// into the expected sequence of memory addresses and NPU events; a monitor
// compares what the DUT presents against those queues. Memory and NPU
// responders run as independent processes.
module tb_tinynpu_layer_sched;

  localparam int SIZE  = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(SIZE);

  localparam int KX    = 0;
  localparam int KW    = 1;
  localparam int KMAC  = 2;
  localparam int KDONE = 3;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_val;
  logic          o_cmd_rdy;
  logic [LW-1:0] i_cmd_len;
  logic [3:0]    i_cmd_layers;
  logic [AW-1:0] i_cmd_base;
  logic          o_mem_req_val;
  logic          i_mem_req_rdy;
  logic [AW-1:0] o_mem_req_addr;
  logic          i_mem_resp_val;
  logic [DW-1:0] i_mem_resp_data;
  logic          o_npu_x_load_val;
  logic          o_npu_w_load_val;
  logic [SW-1:0] o_npu_w_load_sel;
  logic [DW-1:0] o_npu_load_data;
  logic          o_npu_mac_val;
  logic          i_npu_layer_done;
  logic          o_busy;
  logic          o_done;

  typedef struct {
    int            kind;
    int            sel;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           evQ[$];
  logic [AW-1:0] addrQ[$];

  int nChecks = 0;
  int nPass   = 0;
  int wLoadsSeen = 0;
  int fixedLat = 1;
  bit randRdy = 1'b0;
  bit stray = 1'b0;
  int stallArm = 0;

  tinynpu_layer_sched #(.SIZE(SIZE), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_cmd_val        (i_cmd_val),
    .o_cmd_rdy        (o_cmd_rdy),
    .i_cmd_len        (i_cmd_len),
    .i_cmd_layers     (i_cmd_layers),
    .i_cmd_base       (i_cmd_base),
    .o_mem_req_val    (o_mem_req_val),
    .i_mem_req_rdy    (i_mem_req_rdy),
    .o_mem_req_addr   (o_mem_req_addr),
    .i_mem_resp_val   (i_mem_resp_val),
    .i_mem_resp_data  (i_mem_resp_data),
    .o_npu_x_load_val (o_npu_x_load_val),
    .o_npu_w_load_val (o_npu_w_load_val),
    .o_npu_w_load_sel (o_npu_w_load_sel),
    .o_npu_load_data  (o_npu_load_data),
    .o_npu_mac_val    (o_npu_mac_val),
    .i_npu_layer_done (i_npu_layer_done),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return DW'(int'(a) * 37 + 91);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic matchEvent(input int kind, input int sel, input logic [DW-1:0] data);
    ev_t e;
    if (evQ.size() == 0) begin
      checkOutput($sformatf("unexpected event kind %0d", kind), 32'd1, 32'd0);
    end else begin
      e = evQ.pop_front();
      checkOutput("event kind", 32'(kind), 32'(e.kind));
      if (kind == KW && e.kind == KW) checkOutput("w_load_sel", 32'(sel), 32'(e.sel));
      if ((kind == KX || kind == KW) && e.kind == kind) checkOutput("load_data", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: every requested address must match the head of the address
  // queue (also proving stability while stalled); every pulse pops an event.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_mem_req_val) begin
        if (addrQ.size() == 0) begin
          checkOutput("unexpected mem request", 32'd1, 32'd0);
        end else begin
          checkOutput("mem_req_addr", 32'(o_mem_req_addr), 32'(addrQ[0]));
          if (i_mem_req_rdy) void'(addrQ.pop_front());
        end
      end
      if (o_npu_x_load_val) matchEvent(KX, 0, o_npu_load_data);
      if (o_npu_w_load_val) begin
        matchEvent(KW, int'(o_npu_w_load_sel), o_npu_load_data);
        wLoadsSeen++;
      end
      if (o_npu_mac_val) matchEvent(KMAC, 0, '0);
      if (o_done) matchEvent(KDONE, 0, '0);
    end
  end

  // Memory responder: random or fixed latency (0 = same-cycle response),
  // optional ready stalls and stray responses when none is owed.
  initial begin
    bit            pend;
    int            cnt;
    int            lat;
    int            stallLeft;
    int            lastArm;
    logic [AW-1:0] pAddr;
    pend = 0; cnt = 0; stallLeft = 0; lastArm = 0; pAddr = '0;
    i_mem_req_rdy = 1'b0;
    i_mem_resp_val = 1'b0;
    i_mem_resp_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (stallArm != lastArm) begin
        lastArm = stallArm;
        stallLeft = 5;
      end
      i_mem_resp_val = 1'b0;
      i_mem_resp_data = DW'($urandom);
      if (i_rst) begin
        pend = 0;
        i_mem_req_rdy = 1'b0;
      end else if (pend) begin
        i_mem_req_rdy = 1'($urandom);
        cnt--;
        if (cnt == 0) begin
          i_mem_resp_val = 1'b1;
          i_mem_resp_data = memWord(pAddr);
          pend = 0;
        end
      end else if (o_mem_req_val) begin
        if (stallLeft > 0) begin
          i_mem_req_rdy = 1'b0;
          stallLeft--;
        end else begin
          i_mem_req_rdy = randRdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (i_mem_req_rdy) begin
          lat = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
          if (lat == 0) begin
            i_mem_resp_val = 1'b1;
            i_mem_resp_data = memWord(o_mem_req_addr);
          end else begin
            pend = 1;
            cnt = lat;
            pAddr = o_mem_req_addr;
          end
        end else if (stray && $urandom_range(0, 3) == 0) begin
          i_mem_resp_val = 1'b1;
        end
      end else begin
        i_mem_req_rdy = 1'($urandom);
        if (stray && $urandom_range(0, 3) == 0) i_mem_resp_val = 1'b1;
      end
    end
  end

  // NPU responder: layer_done a few cycles after each MAC pulse, plus stray
  // layer_done pulses while no layer is running.
  initial begin
    bit outstanding;
    int delay;
    outstanding = 0; delay = 0;
    i_npu_layer_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      i_npu_layer_done = 1'b0;
      if (i_rst) begin
        outstanding = 0;
      end else if (o_npu_mac_val) begin
        outstanding = 1;
        delay = $urandom_range(1, 4);
      end else if (outstanding) begin
        delay--;
        if (delay == 0) begin
          i_npu_layer_done = 1'b1;
          outstanding = 0;
        end
      end else if (stray && $urandom_range(0, 3) == 0) begin
        i_npu_layer_done = 1'b1;
      end
    end
  end

  // Expand a command into expected addresses/events, then issue it.
  task automatic applyStimulus(input int len, input int layers, input logic [AW-1:0] base);
    int            k;
    bit            degen;
    int            cyc;
    logic [AW-1:0] a;
    k = (len > DEPTH) ? DEPTH : len;
    degen = (k == 0) || (layers == 0);
    if (!degen) begin
      for (int i = 0; i < k; i++) begin
        a = AW'(int'(base) + i);
        addrQ.push_back(a);
        evQ.push_back('{kind: KX, sel: 0, data: memWord(a)});
      end
      for (int l = 0; l < layers; l++) begin
        for (int r = 0; r < SIZE; r++) begin
          for (int i = 0; i < k; i++) begin
            a = AW'(int'(base) + k + l * SIZE * k + r * k + i);
            addrQ.push_back(a);
            evQ.push_back('{kind: KW, sel: r, data: memWord(a)});
          end
        end
        evQ.push_back('{kind: KMAC, sel: 0, data: '0});
      end
    end
    evQ.push_back('{kind: KDONE, sel: 0, data: '0});
    cyc = 0;
    while (!o_cmd_rdy && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    i_cmd_len = LW'(len);
    i_cmd_layers = 4'(layers);
    i_cmd_base = base;
    i_cmd_val = 1'b1;
    @(posedge clk);
    #1;
    i_cmd_val = 1'b0;
    @(negedge clk);
    checkOutput("busy after accept", 32'(o_busy), 32'd1);
    checkOutput("cmd_rdy while busy", 32'(o_cmd_rdy), 32'd0);
    if (degen) checkOutput("degenerate done next cycle", 32'(o_done), 32'd1);
  endtask

  task automatic waitIdle();
    int cyc;
    cyc = 0;
    while (!(evQ.size() == 0 && addrQ.size() == 0 && o_cmd_rdy) && cyc < 5000) begin
      @(posedge clk);
      #3;
      cyc++;
    end
    checkOutput("command completes in time", 32'(cyc < 5000), 32'd1);
    checkOutput("idle busy", 32'(o_busy), 32'd0);
    checkOutput("idle cmd_rdy", 32'(o_cmd_rdy), 32'd1);
    evQ.delete();
    addrQ.delete();
  endtask

  initial begin
    int cyc;
    int startW;
    i_rst = 1'b1;
    i_cmd_val = 1'b0;
    i_cmd_len = '0;
    i_cmd_layers = '0;
    i_cmd_base = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cmd_rdy", 32'(o_cmd_rdy), 32'd1);
    checkOutput("reset busy", 32'(o_busy), 32'd0);
    checkOutput("reset done", 32'(o_done), 32'd0);
    checkOutput("reset mem_req_val", 32'(o_mem_req_val), 32'd0);
    checkOutput("reset loads", 32'({o_npu_x_load_val, o_npu_w_load_val, o_npu_mac_val}), 32'd0);
    checkOutput("reset load_data", 32'(o_npu_load_data), 32'd0);
    @(negedge clk);
    i_rst = 1'b0;

    fixedLat = 1;
    applyStimulus(2, 1, 8'h10);
    waitIdle();
    applyStimulus(3, 2, 8'h00);
    waitIdle();
    stallArm = stallArm + 1;
    applyStimulus(2, 1, 8'h20);
    waitIdle();
    applyStimulus(0, 2, 8'h30);
    waitIdle();
    applyStimulus(3, 0, 8'h30);
    waitIdle();
    applyStimulus(2, 1, 8'hFE);
    waitIdle();

    // Reset in the middle of the weight phase.
    startW = wLoadsSeen;
    applyStimulus(3, 2, 8'h40);
    cyc = 0;
    while (wLoadsSeen < startW + 3 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput("reached weight phase", 32'(wLoadsSeen >= startW + 3), 32'd1);
    #3;
    i_rst = 1'b1;
    #1;
    checkOutput("mid reset mem_req_val", 32'(o_mem_req_val), 32'd0);
    checkOutput("mid reset pulses", 32'({o_npu_x_load_val, o_npu_w_load_val, o_npu_mac_val, o_done}), 32'd0);
    checkOutput("mid reset busy", 32'(o_busy), 32'd0);
    checkOutput("mid reset cmd_rdy", 32'(o_cmd_rdy), 32'd1);
    evQ.delete();
    addrQ.delete();
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    stray = 1'b1;
    repeat (20) @(posedge clk);
    stray = 1'b0;
    #3;
    checkOutput("idle after stray inputs", 32'(o_busy), 32'd0);
    applyStimulus(2, 1, 8'h80);
    waitIdle();

    // Randomised commands with random latency, ready stalls and strays.
    fixedLat = -1;
    randRdy = 1'b1;
    stray = 1'b1;
    for (int t = 0; t < 12; t++) begin
      applyStimulus(int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), AW'($urandom));
      waitIdle();
    end
    stray = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
